spi_regfile_periph: RTL and testbench

- Parametrised next-generation SPI target register file: NUM_REGS registers of DATA_W bits, written and read by an external SPI controller.
- Adds over the previous write-only, fixed-5-register peripheral: readback on CIPO, selectable SPI mode (CPOL/CPHA), and a one-cycle write strobe for downstream PWM/GPIO logic.
- Sits between the chip's SPI pins and the output-enable/PWM configuration logic, all in the clk domain.

---
 rtl/spi_pkg.sv | 30 +++
 rtl/spi_sync_edge.sv | 37 +++
 rtl/spi_regfile_periph.sv | 259 +++++++++++++++++++++++++
 tb/tb_spi_regfile_periph.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target register file.
//   - spi_state_e   : frame FSM states
//   - RW_WRITE/READ : encoding of the leading R/W bit of a frame
//   - frame_width() : total frame length for a given address/data width
//   - OUT_7_0 .. DUTY : default register map of the 5-register configuration
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData,
    StHold
  } spi_state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam int unsigned OUT_7_0  = 0;
  localparam int unsigned OUT_15_8 = 1;
  localparam int unsigned PWM_7_0  = 2;
  localparam int unsigned PWM_15_8 = 3;
  localparam int unsigned DUTY     = 4;

  // R/W bit + address + data, MSB first on the wire.
  function automatic int unsigned frame_width(input int unsigned addr_w,
                                              input int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin plus edge detection.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   d          : asynchronous input pin
//   q          : synchronised level
//   rise, fall : one-cycle pulses on synchronised rising / falling edges
// Parameters: SYNC_STAGES (>= 2), RST_VAL (level the chain and edge flop reset to).
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_regfile_periph.sv
// SPI target register file: NUM_REGS registers of DATA_W bits, written and read back by
// an external SPI controller in a selectable CPOL/CPHA mode. All logic runs on clk; the
// SPI pins are oversampled through synchronisers.
// Ports:
//   clk, rst_n        : system clock, asynchronous active-low reset
//   ncs, sclk, copi   : asynchronous SPI inputs
//   cipo, cipo_oe     : SPI read data and its pad output enable
//   regs_out          : flattened registers, reg k at [k*DATA_W +: DATA_W]
//   wr_strobe/wr_addr : one-cycle pulse and address of each committed write
//   abort_cnt         : saturating count of aborted frames and out-of-range writes
// Build option: define SPI_ABORT_CNT_EN to implement abort_cnt; otherwise it reads 0.
module spi_regfile_periph
  import spi_pkg::*;
#(
  parameter int unsigned       NUM_REGS    = 5,
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       ADDR_W      = 7,
  parameter logic              CPOL        = 1'b0,
  parameter logic              CPHA        = 1'b0,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RST_VAL     = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ncs,
  input  logic                         sclk,
  input  logic                         copi,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [7:0]                   abort_cnt
);

  localparam int unsigned FrameW = frame_width(ADDR_W, DATA_W);
  localparam int unsigned CmdW   = 1 + ADDR_W;
  // One extra code above FrameW marks an overlong frame.
  localparam int unsigned CntW   = $clog2(FrameW + 2);
  localparam logic [ADDR_W:0] NumRegsW = (ADDR_W + 1)'(NUM_REGS);
  localparam logic SampleRise = (CPOL == CPHA);

  // ---------------------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------------------
  logic ncs_s, ncs_rise, ncs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic copi_s, copi_rise, copi_fall;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b1)
  ) u_sync_ncs (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ncs),
    .q    (ncs_s),
    .rise (ncs_rise),
    .fall (ncs_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (CPOL)
  ) u_sync_sclk (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sclk),
    .q    (sclk_s),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b0)
  ) u_sync_copi (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (copi),
    .q    (copi_s),
    .rise (copi_rise),
    .fall (copi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_s, copi_rise, copi_fall};

  logic sample_edge, launch_edge;
  assign sample_edge = SampleRise ? sclk_rise : sclk_fall;
  assign launch_edge = SampleRise ? sclk_fall : sclk_rise;

  // ---------------------------------------------------------------------------------------
  // Register storage
  // ---------------------------------------------------------------------------------------
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
    assign regs_out[k*DATA_W +: DATA_W] = regs_q[k];
  end

  // ---------------------------------------------------------------------------------------
  // Frame datapath
  // ---------------------------------------------------------------------------------------
  spi_state_e state_q, state_d;

  logic [FrameW-1:0] shift_q, shift_d, shift_in;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0] shadow_q, shadow_d, rd_data;
  logic              cipo_q, cipo_d;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_req;

  assign shift_in = {shift_q[FrameW-2:0], copi_s};
  assign cnt_inc  = cnt_q + 1'b1;
  // Valid at the sample edge that completes the command field.
  assign rd_addr  = shift_in[ADDR_W-1:0];
  assign rd_req   = (shift_in[ADDR_W] == RW_READ);

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_addr == ADDR_W'(k)) rd_data = regs_q[k];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic; ncs rising wins over any same-cycle sclk edge.
  always_comb begin
    state_d = state_q;
    if (ncs_rise) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (ncs_fall) state_d = StCmd;
        StCmd:  if (sample_edge && (cnt_inc == CntW'(CmdW))) state_d = StData;
        StData: if (sample_edge && (cnt_inc == CntW'(FrameW))) state_d = StHold;
        StHold: state_d = StHold;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs: cipo only driven during the data phase.
  always_comb begin
    cipo    = (state_q == StData) ? cipo_q : 1'b0;
    cipo_oe = ~ncs_s;
  end

  // Shift register, bit counter and read shadow
  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    cipo_d   = cipo_q;
    if (ncs_rise) begin
      cipo_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ncs_fall) begin
            shift_d  = '0;
            cnt_d    = '0;
            shadow_d = '0;
            cipo_d   = 1'b0;
          end
        end
        StCmd, StData: begin
          if (sample_edge) begin
            shift_d = shift_in;
            cnt_d   = cnt_inc;
            if ((state_q == StCmd) && (cnt_inc == CntW'(CmdW)) && rd_req) shadow_d = rd_data;
          end else if (launch_edge && (state_q == StData)) begin
            cipo_d   = shadow_q[DATA_W-1];
            shadow_d = shadow_q << 1;
          end
        end
        StHold: begin
          if (sample_edge) cnt_d = CntW'(FrameW + 1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      cipo_q   <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      cipo_q   <= cipo_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Commit / abort decision at the end of a frame
  // ---------------------------------------------------------------------------------------
  logic              frame_end, frame_full, fr_write, addr_ok, commit, abort;
  logic [ADDR_W-1:0] fr_addr;

  assign fr_addr    = shift_q[FrameW-2 -: ADDR_W];
  assign fr_write   = (shift_q[FrameW-1] == RW_WRITE);
  assign addr_ok    = ({1'b0, fr_addr} < NumRegsW);
  assign frame_full = (cnt_q == CntW'(FrameW));
  assign frame_end  = ncs_rise && (state_q != StIdle);
  assign commit     = frame_end && frame_full && fr_write && addr_ok;
  assign abort      = frame_end && (!frame_full || (fr_write && !addr_ok));

  logic              wr_strobe_q;
  logic [ADDR_W-1:0] wr_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= RST_VAL;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      wr_strobe_q <= commit;
      if (commit) begin
        wr_addr_q <= fr_addr;
        for (int k = 0; k < NUM_REGS; k++) begin
          if (fr_addr == ADDR_W'(k)) regs_q[k] <= shift_q[DATA_W-1:0];
        end
      end
    end
  end

  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;

`ifdef SPI_ABORT_CNT_EN
  logic [7:0] abort_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort_cnt_q <= '0;
    end else if (abort && (abort_cnt_q != 8'hFF)) begin
      abort_cnt_q <= abort_cnt_q + 8'd1;
    end
  end

  assign abort_cnt = abort_cnt_q;
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_cnt    = '0;
`endif

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Bench for spi_regfile_periph: a mode-0 instance (non-zero reset value) and a mode-3
// instance share one SPI driver; sel picks which one sees the bus. Expected writes and
// read data are queued when a frame is driven and consumed when the DUT responds.
`timescale 1ns/1ps
module tb_spi_regfile_periph;

  localparam int unsigned NUM_REGS = 5;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned FLAT_W   = NUM_REGS * DATA_W;
  localparam logic [7:0]  RST0     = 8'h5A;
  localparam logic [7:0]  RST3     = 8'h00;
  localparam int          SCLK_HALF = 60;
  localparam int          GAP       = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sel   = 1'b0;
  logic ncs_drv = 1'b1, sclk_drv = 1'b0, copi_drv = 1'b0;

  logic ncs0, sclk0, ncs3, sclk3;
  assign ncs0  = sel ? 1'b1 : ncs_drv;
  assign sclk0 = sel ? 1'b0 : sclk_drv;
  assign ncs3  = sel ? ncs_drv : 1'b1;
  assign sclk3 = sel ? sclk_drv : 1'b1;

  logic              cipo0, cipo_oe0, wr_strobe0, cipo3, cipo_oe3, wr_strobe3;
  logic [FLAT_W-1:0] regs0, regs3;
  logic [ADDR_W-1:0] wr_addr0, wr_addr3;
  logic [7:0]        abort0, abort3;

  spi_regfile_periph #(
    .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CPOL(1'b0), .CPHA(1'b0),
    .SYNC_STAGES(2), .RST_VAL(RST0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ncs(ncs0), .sclk(sclk0), .copi(copi_drv),
    .cipo(cipo0), .cipo_oe(cipo_oe0), .regs_out(regs0), .wr_strobe(wr_strobe0),
    .wr_addr(wr_addr0), .abort_cnt(abort0)
  );

  spi_regfile_periph #(
    .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CPOL(1'b1), .CPHA(1'b1),
    .SYNC_STAGES(2), .RST_VAL(RST3)
  ) dut_m3 (
    .clk(clk), .rst_n(rst_n), .ncs(ncs3), .sclk(sclk3), .copi(copi_drv),
    .cipo(cipo3), .cipo_oe(cipo_oe3), .regs_out(regs3), .wr_strobe(wr_strobe3),
    .wr_addr(wr_addr3), .abort_cnt(abort3)
  );

  logic              cipo_m, cipo_oe_m;
  logic [FLAT_W-1:0] regs_m;
  logic [7:0]        abort_m;
  assign cipo_m    = sel ? cipo3 : cipo0;
  assign cipo_oe_m = sel ? cipo_oe3 : cipo_oe0;
  assign regs_m    = sel ? regs3 : regs0;
  assign abort_m   = sel ? abort3 : abort0;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [DATA_W-1:0] mdl [2][NUM_REGS];
  int                mdl_abort [2];

  typedef struct packed {
    logic              m3;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_exp_t;

  wr_exp_t           exp_wr_q [$];
  logic [DATA_W-1:0] exp_rd_q [$];
  int                strobe_cnt = 0;

  function automatic logic [FLAT_W-1:0] mdl_flat(input int m);
    logic [FLAT_W-1:0] f;
    for (int k = 0; k < NUM_REGS; k++) f[k*DATA_W +: DATA_W] = mdl[m][k];
    return f;
  endfunction

  function automatic logic [7:0] exp_abort(input int m);
`ifdef SPI_ABORT_CNT_EN
    return (mdl_abort[m] > 255) ? 8'hFF : 8'(mdl_abort[m]);
`else
    return (m > 1) ? 8'hFF : 8'h00;
`endif
  endfunction

  // Write-commit monitor
  always @(negedge clk) begin
    wr_exp_t e;
    if (rst_n && (wr_strobe0 || wr_strobe3)) begin
      strobe_cnt++;
      check("strobe_expected", 64'(exp_wr_q.size() != 0), 1);
      if (exp_wr_q.size() != 0) begin
        e = exp_wr_q.pop_front();
        check("strobe_instance", wr_strobe3, e.m3);
        check("wr_addr", e.m3 ? wr_addr3 : wr_addr0, e.addr);
        check("wr_data", e.m3 ? regs3[int'(e.addr)*DATA_W +: DATA_W]
                              : regs0[int'(e.addr)*DATA_W +: DATA_W], e.data);
      end
    end
  end

  task automatic model_reset();
    for (int k = 0; k < NUM_REGS; k++) begin
      mdl[0][k] = RST0;
      mdl[1][k] = RST3;
    end
    mdl_abort[0] = 0;
    mdl_abort[1] = 0;
  endtask

  // Shift nbits of frame (MSB first); cipo captured just before every rising (sample) edge.
  task automatic spi_bits(input logic [31:0] frame, input int nbits, output logic [31:0] samp);
    samp = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      if (sel) sclk_drv = 1'b0;
      copi_drv = frame[i];
      #(SCLK_HALF);
      samp = {samp[30:0], cipo_m};
      sclk_drv = 1'b1;
      #(SCLK_HALF);
      if (!sel) sclk_drv = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [31:0] frame, input int nbits);
    int                m = sel ? 1 : 0;
    int                s0 = strobe_cnt;
    int                exp_strobes = 0;
    bit                is_read = 1'b0;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d, e;
    logic [31:0]       samp;
    wr_exp_t           w;
    if (nbits == 16) begin
      a = frame[14:8];
      d = frame[7:0];
      if (frame[15]) begin
        if (a < NUM_REGS) begin
          mdl[m][int'(a)] = d;
          w.m3 = sel; w.addr = a; w.data = d;
          exp_wr_q.push_back(w);
          exp_strobes = 1;
        end else begin
          mdl_abort[m]++;
        end
      end else begin
        is_read = 1'b1;
        exp_rd_q.push_back((a < NUM_REGS) ? mdl[m][int'(a)] : 8'h00);
      end
    end else begin
      mdl_abort[m]++;
    end
    ncs_drv = 1'b0;
    #(SCLK_HALF);
    check("cipo_oe_active", cipo_oe_m, 1);
    spi_bits(frame, nbits, samp);
    #(SCLK_HALF);
    ncs_drv  = 1'b1;
    copi_drv = 1'b0;
    #(GAP);
    check("strobe_count", 64'(strobe_cnt - s0), 64'(exp_strobes));
    check("cipo_oe_idle", cipo_oe_m, 0);
    check("cipo_idle", cipo_m, 0);
    if (is_read) begin
      e = exp_rd_q.pop_front();
      check("rd_data", samp[7:0], e);
      check("rd_cmd_phase_cipo", samp[15:8], 0);
    end
    check("regs", regs_m, mdl_flat(m));
    check("abort_cnt", abort_m, exp_abort(m));
  endtask

  initial begin
    logic [31:0] samp;
    model_reset();
    #20;
    check("rst_cipo_oe", cipo_oe0, 0);
    check("rst_regs0", regs0, mdl_flat(0));
    check("rst_regs3", regs3, mdl_flat(1));
    rst_n = 1'b1;
    #40;
    check("rst_wr_strobe", wr_strobe0, 0);
    check("rst_wr_addr", wr_addr0, 0);
    check("rst_cipo", cipo0, 0);
    check("rst_abort_cnt", abort0, 0);
    check("rst_cipo_oe_m3", cipo_oe3, 0);

    // Mode 0 instance
    spi_frame(32'h80F0, 16);
    check("wr_addr_after_w0", wr_addr0, 0);
    spi_frame(32'h8480, 16);
    spi_frame(32'h0400, 16);
    spi_frame(32'h0100, 16);
    spi_frame(32'h8133 >> 1, 15);
    spi_frame((32'h8133 << 1) | 32'h1, 17);
    spi_frame(32'h9077, 16);
    spi_frame(32'h1000, 16);
    check("wr_addr_last", wr_addr0, 4);

    // Mode 3 instance
    sel = 1'b1;
    sclk_drv = 1'b1;
    #(GAP);
    spi_frame(32'h83AA, 16);
    spi_frame(32'h0300, 16);
    check("wr_addr_m3", wr_addr3, 3);

    // Reset in the middle of a mode-0 write, released with ncs still low
    sel = 1'b0;
    sclk_drv = 1'b0;
    #(GAP);
    ncs_drv = 1'b0;
    #(SCLK_HALF);
    spi_bits(32'h81C3 >> 10, 6, samp);
    rst_n = 1'b0;
    model_reset();
    #30;
    check("midrst_regs0", regs0, mdl_flat(0));
    check("midrst_regs3", regs3, mdl_flat(1));
    rst_n = 1'b1;
    #(SCLK_HALF);
    spi_bits(32'h81C3 & 32'h3FF, 10, samp);
    #(SCLK_HALF);
    ncs_drv = 1'b1;
    copi_drv = 1'b0;
    mdl_abort[0]++;
    #(GAP);
    check("midrst_no_commit", regs0, mdl_flat(0));
    check("midrst_abort_cnt", abort0, exp_abort(0));
    check("midrst_no_strobe", wr_addr0, 0);
    spi_frame(32'h8255, 16);
    spi_frame(32'h0200, 16);

    check("wr_queue_drained", 64'(exp_wr_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
